second_display: RTL and testbench
=================================

# second_display

Display back-end for the traffic-light countdown. Takes the 7-bit binary seconds value produced by the countdown counter and converts it to two BCD digits with an iterative shift-add-3 converter. It then time-multiplexes the digits onto a two-digit common-anode seven-segment display. It sits between the counter's `second` output and the board display pins.

## Interface
Parameters:
- `pSCAN_DIV`, default 50000: clock cycles per digit slot; must be ≥ 2.
- `pBLANK_LEADING`, default 1: 1 = blank the tens digit when it is 0.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `en`  in  1: display enable; 0 = both digits dark.
- `second`  in  7: binary seconds value, 0..127.
- `seg`  out  7: segments {g,f,e,d,c,b,a}, active-low, registered.
- `an`  out  2: digit anodes, active-low, registered; an[0] = ones, an[1] = tens.

## Operation
- **Clamping.** The input is clamped to 99: `clamped = (second > 99) ? 99 : second`.
- **Converter FSM states:**
  - IDLE. When `clamped != cap_val`, capture `clamped` into `cap_val` and into the shift source. Clear the BCD working registers and the bit counter, then go to CONV. Otherwise stay.
  - CONV. Each cycle, add 3 to any working BCD nibble ≥ 5, then shift left one bit, taking the next MSB of the source. After the 7th CONV cycle, write the tens/ones result into the display digit registers (both in the same edge) and return to IDLE.
- Changes on `second` while in CONV are ignored. They are picked up on the next IDLE cycle by comparing against `cap_val`.
- The display digit registers only ever change together, atomically. A partial or torn value is never displayed.
- **Scan logic:**
  - A refresh counter runs 0..pSCAN_DIV-1. At the terminal count it wraps to 0 and toggles `dsel` (0 = ones, 1 = tens).
  - Slot ones: `an = 2'b10`, seg = pattern(ones).
  - Slot tens: `an = 2'b01`, seg = pattern(tens).
  - Exception in the tens slot: if pBLANK_LEADING = 1 and tens == 0, then `an = 2'b11` and `seg = 7'h7F`.
- **Segment patterns** ({g..a}, active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - blank = 1111111
- **Enable low.** When `en` = 0:
  - Refresh counter is held at 0 and `dsel` = 0.
  - `an = 2'b11`, `seg = 7'h7F`.
  - The converter keeps running, so digits stay current.
- **Enable rising.** Scanning restarts in the ones slot with a full pSCAN_DIV period.

## Timing
- **Reset values (after any clock edge with `rst` = 1):**
  - `seg = 7'h7F`, `an = 2'b11`.
  - FSM = IDLE, `cap_val = 0`, tens = 0, ones = 0.
  - Refresh counter = 0, `dsel` = 0.
- **Reset priority.** `rst` overrides everything, including `en`. Asserting it mid-CONV aborts the conversion with no digit update.
- **Conversion latency.** Let E0 be the capture edge (IDLE, value differs). The digit registers update on E7. `seg`/`an` reflect the new digits on E8 if the slot is currently active.
- **Minimum spacing.** Back-to-back conversions are at least 8 edges apart: one IDLE cycle plus 7 CONV cycles.
- **Output registration.** `seg` and `an` come from the same register stage, so they change on the same edge (no ghosting). The output lags the `dsel` and digit registers by one cycle.
- **Scan rate.** `dsel` toggles every pSCAN_DIV clocks, so the full frame is 2·pSCAN_DIV clocks.
- **Refresh counter width.** `$clog2(pSCAN_DIV)`, with a minimum of 1 bit.
- **Steady input.** An input that holds a value equal to `cap_val` causes no conversion activity.

## Test plan
1. **Reset and zero.** `rst` = 1 for 2 cycles → `seg = 7F`, `an = 11`. Release with `second` = 0, `en` = 1, pSCAN_DIV = 4:
   - ones slot → `an = 10`, `seg = 1000000`
   - tens slot → `an = 11`, `seg = 7F` (blanked)
2. **Conversion of 42.** `second` = 42 → digit registers update 7 edges after capture:
   - ones slot → `seg = 0100100`, `an = 10`
   - tens slot → `seg = 0011001`, `an = 01`
3. **Clamp.** `second` = 127 → displays 9/9 (`0010000` in both slots). Then `second` = 100 → no new conversion, because the clamped value is unchanged.
4. **Change mid-conversion.** `second` 42 → 17 on the 3rd CONV cycle → 42 is displayed first; 17 (ones `1111000`, tens `1111001`) is displayed 8 edges after the next IDLE capture.
5. **Scan rate.** With pSCAN_DIV = 4, `an` alternates between 10 and 01 every 4 clocks. With `en` = 0, the next edge gives `an = 11`, `seg = 7F`. Raising `en` again → ones slot first.
6. **Reset mid-conversion.** Assert `rst` during CONV of 85 → digits read 0 after reset. Releasing with `second` = 85 reconverts and shows 85.

Source files
------------

// File: rtl/second_display.sv
// -----------------------------------------------------------------------------
// second_display
//
// Display back-end for the traffic-light countdown. Converts a 7-bit binary
// seconds value into two BCD digits with an iterative shift-add-3 converter,
// then time-multiplexes the digits onto a two-digit common-anode
// seven-segment display.
//
// Parameters:
//   pSCAN_DIV      : clock cycles per digit slot (>= 2)
//   pBLANK_LEADING : 1 = blank the tens digit when it is 0
//
// Ports:
//   clk    in  1 : single clock, all state updates on the rising edge
//   rst    in  1 : synchronous active-high reset
//   en     in  1 : display enable, 0 = both digits dark
//   second in  7 : binary seconds value 0..127 (clamped to 99)
//   seg    out 7 : segments {g,f,e,d,c,b,a}, active-low, registered
//   an     out 2 : digit anodes, active-low, registered; an[0]=ones, an[1]=tens
// -----------------------------------------------------------------------------
module second_display #(
    parameter int pSCAN_DIV      = 50000,
    parameter bit pBLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] second,
    output logic [6:0] seg,
    output logic [1:0] an
);

    // Refresh counter width: $clog2(pSCAN_DIV), never less than one bit.
    localparam int CW = ($clog2(pSCAN_DIV) < 1) ? 1 : $clog2(pSCAN_DIV);
    localparam logic [CW-1:0] SCAN_TERM = CW'(pSCAN_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [1:0] AN_OFF    = 2'b11;
    localparam logic [1:0] AN_ONES   = 2'b10;
    localparam logic [1:0] AN_TENS   = 2'b01;

    // -------------------------------------------------------------------------
    // Converter state
    // -------------------------------------------------------------------------
    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } conv_state_t;

    conv_state_t state;
    logic [6:0]  cap_val;   // last value handed to the converter
    logic [6:0]  src;       // shift source, MSB consumed first
    logic [7:0]  bcd;       // working BCD: [7:4] tens, [3:0] ones
    logic [2:0]  bit_cnt;   // CONV cycles already completed
    logic [3:0]  tens;      // displayed tens digit
    logic [3:0]  ones;      // displayed ones digit

    logic [6:0]  clamped;
    logic [7:0]  bcd_adj;
    logic [7:0]  bcd_shift;

    always_comb begin
        clamped = (second > 7'd99) ? 7'd99 : second;

        // Add-3 correction on any nibble >= 5 before it is doubled by the shift.
        bcd_adj = bcd;
        if (bcd[3:0] >= 4'd5) begin
            bcd_adj[3:0] = bcd[3:0] + 4'd3;
        end
        if (bcd[7:4] >= 4'd5) begin
            bcd_adj[7:4] = bcd[7:4] + 4'd3;
        end

        bcd_shift = {bcd_adj[6:0], src[6]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cap_val <= 7'd0;
            src     <= 7'd0;
            bcd     <= 8'd0;
            bit_cnt <= 3'd0;
            tens    <= 4'd0;
            ones    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    // Input changes while converting are not lost: they show
                    // up here as a mismatch against cap_val.
                    if (clamped != cap_val) begin
                        cap_val <= clamped;
                        src     <= clamped;
                        bcd     <= 8'd0;
                        bit_cnt <= 3'd0;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    bcd     <= bcd_shift;
                    src     <= {src[5:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                    // Seventh shift: both digits load on the same edge so the
                    // scanner never sees a half-updated number.
                    if (bit_cnt == 3'd6) begin
                        tens  <= bcd_shift[7:4];
                        ones  <= bcd_shift[3:0];
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Scan timing
    // -------------------------------------------------------------------------
    logic [CW-1:0] refresh_cnt;
    logic          dsel;        // 0 = ones slot, 1 = tens slot

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            dsel        <= 1'b0;
        end else if (!en) begin
            // Held here so a re-enable starts with a full ones slot.
            refresh_cnt <= '0;
            dsel        <= 1'b0;
        end else if (refresh_cnt == SCAN_TERM) begin
            refresh_cnt <= '0;
            dsel        <= ~dsel;
        end else begin
            refresh_cnt <= refresh_cnt + CW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Segment decode and output register
    // -------------------------------------------------------------------------
    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        logic [6:0] p;
        case (digit)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    logic [6:0] seg_d;
    logic [1:0] an_d;

    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = AN_OFF;
        if (en) begin
            if (!dsel) begin
                seg_d = seg_pattern(ones);
                an_d  = AN_ONES;
            end else if (!(pBLANK_LEADING && (tens == 4'd0))) begin
                seg_d = seg_pattern(tens);
                an_d  = AN_TENS;
            end
        end
    end

    // seg and an share one register stage so segments and anode always
    // switch on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_BLANK;
            an  <= AN_OFF;
        end else begin
            seg <= seg_d;
            an  <= an_d;
        end
    end

endmodule

// File: tb/tb_second_display.sv
module tb_second_display;

    logic       clk;
    logic       rst;
    logic       en;
    logic [6:0] second;
    logic [6:0] seg;
    logic [1:0] an;

    int n_tests = 0;
    int n_fail  = 0;

    second_display #(
        .pSCAN_DIV      (4),
        .pBLANK_LEADING (1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .second (second),
        .seg    (seg),
        .an     (an)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] sec;
        logic [6:0] ones_seg;
        logic [1:0] tens_an;
        logic [6:0] tens_seg;
    } vec_t;

    vec_t vecs[10];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Advance (bounded) until the anode pattern matches the wanted slot.
    task automatic wait_an(input logic [1:0] want, input string name);
        int k;
        k = 0;
        while (an !== want && k < 16) begin
            @(negedge clk);
            k++;
        end
        if (an !== want) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: timeout, an=%b expected %b", name, an, want);
        end
    endtask

    task automatic check_out(input string name, input logic [1:0] exp_an, input logic [6:0] exp_seg);
        check({name, "_an"},  {6'd0, an}, {6'd0, exp_an});
        check({name, "_seg"}, {1'b0, seg}, {1'b0, exp_seg});
    endtask

    initial begin
        // sec, ones seg, tens an, tens seg
        vecs[0] = '{7'd0,   7'h40, 2'b11, 7'h7F};
        vecs[1] = '{7'd42,  7'h24, 2'b01, 7'h19};
        vecs[2] = '{7'd127, 7'h10, 2'b01, 7'h10};
        vecs[3] = '{7'd100, 7'h10, 2'b01, 7'h10};
        vecs[4] = '{7'd5,   7'h12, 2'b11, 7'h7F};
        vecs[5] = '{7'd10,  7'h40, 2'b01, 7'h79};
        vecs[6] = '{7'd59,  7'h10, 2'b01, 7'h12};
        vecs[7] = '{7'd87,  7'h78, 2'b01, 7'h00};
        vecs[8] = '{7'd99,  7'h10, 2'b01, 7'h10};
        vecs[9] = '{7'd63,  7'h30, 2'b01, 7'h02};

        // Reset
        rst = 1'b1;
        en = 1'b1;
        second = 7'd0;
        tick(2);
        check_out("reset", 2'b11, 7'h7F);
        rst = 1'b0;
        tick(1);
        check_out("zero_first_ones", 2'b10, 7'h40);

        // Table-driven values
        for (int i = 0; i < 10; i++) begin
            second = vecs[i].sec;
            tick(20);
            wait_an(2'b10, $sformatf("vec%0d_wait_ones", i));
            check($sformatf("vec%0d_ones_seg", i), {1'b0, seg}, {1'b0, vecs[i].ones_seg});
            wait_an(vecs[i].tens_an, $sformatf("vec%0d_wait_tens", i));
            check($sformatf("vec%0d_tens_seg", i), {1'b0, seg}, {1'b0, vecs[i].tens_seg});
        end

        // Exact latency and scan rate: en rises with the capture edge E0
        en = 1'b0;
        second = 7'd63;
        tick(1);
        check_out("en_low", 2'b11, 7'h7F);
        tick(20);
        second = 7'd42;
        en = 1'b1;
        tick(4);
        check_out("lat_e3_ones_old", 2'b10, 7'h30);
        tick(1);
        check_out("lat_e4_tens_old", 2'b01, 7'h02);
        tick(3);
        check_out("lat_e7_tens_old", 2'b01, 7'h02);
        tick(1);
        check_out("lat_e8_ones_new", 2'b10, 7'h24);
        en = 1'b0;
        tick(1);
        check_out("en_drop", 2'b11, 7'h7F);

        // Change during conversion: 42 shows first, then 17
        second = 7'd63;
        tick(20);
        second = 7'd42;
        en = 1'b1;
        tick(3);
        second = 7'd17;
        tick(6);
        check_out("mid_e8_ones42", 2'b10, 7'h24);
        tick(4);
        check_out("mid_e12_tens42", 2'b01, 7'h19);
        tick(3);
        check_out("mid_e15_tens42", 2'b01, 7'h19);
        tick(1);
        check_out("mid_e16_ones17", 2'b10, 7'h78);
        tick(4);
        check_out("mid_e20_tens17", 2'b01, 7'h79);

        // Reset during conversion of 85
        second = 7'd85;
        tick(3);
        rst = 1'b1;
        tick(1);
        check_out("rst_mid", 2'b11, 7'h7F);
        rst = 1'b0;
        tick(1);
        check_out("rst_digits_zero", 2'b10, 7'h40);
        tick(20);
        wait_an(2'b10, "rc85_wait_ones");
        check("rc85_ones_seg", {1'b0, seg}, {1'b0, 7'h12});
        wait_an(2'b01, "rc85_wait_tens");
        check("rc85_tens_seg", {1'b0, seg}, {1'b0, 7'h00});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
